// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller states, default widths and the MISR
// compaction step shared by the controller and the pattern generator model.
package bist_pkg;

   localparam int unsigned N_DEF      = 8;
   localparam int unsigned CW_DEF     = 16;
   localparam int unsigned MISR_MAX_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_COMPARE,
      ST_DONE
   } state_t;

   // Operates on a max-width vector so any instance width w <= MISR_MAX_W can
   // share it; bits at and above w are returned as zero.
   function automatic logic [MISR_MAX_W-1:0] misr_next(
      input logic [MISR_MAX_W-1:0] s,
      input logic [MISR_MAX_W-1:0] d,
      input logic [MISR_MAX_W-1:0] poly,
      input int unsigned           w
   );
      logic [MISR_MAX_W-1:0] nxt;
      nxt = '0;
      for (int unsigned i = 0; i < MISR_MAX_W; i++) begin
         if (i + 1 < w)
            nxt[i] = (s[0] & poly[i]) ^ s[i+1] ^ d[i];
         else if (i + 1 == w)
            nxt[i] = s[0] ^ d[i];
      end
      return nxt;
   endfunction

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register with synchronous load and compact enable.
module misr_reg
   import bist_pkg::*;
#(
   parameter int unsigned N = N_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         en,
   input  logic [N-1:0] d,
   input  logic [N-1:0] poly,
   output logic [N-1:0] q
);

   logic [N-1:0]            sig_q, sig_d;
   logic [MISR_MAX_W-1:0]   s_ext, d_ext, p_ext, nxt_ext;

   always_comb begin
      s_ext          = '0;
      d_ext          = '0;
      p_ext          = '0;
      s_ext[N-1:0]   = sig_q;
      d_ext[N-1:0]   = d;
      p_ext[N-1:0]   = poly;
      nxt_ext        = misr_next(s_ext, d_ext, p_ext, N);
      sig_d          = sig_q;
      if (load)
         sig_d = load_val;
      else if (en)
         sig_d = nxt_ext[N-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sig_q <= '0;
      else
         sig_q <= sig_d;
   end

   assign q = sig_q;

endmodule

// File: rtl/bist_misr_ctrl.sv
// BIST response stage: gates the pattern generator for a programmed count,
// compacts CUT responses into a MISR and compares against a golden signature.
module bist_misr_ctrl
   import bist_pkg::*;
#(
   parameter int unsigned N  = N_DEF,
   parameter int unsigned CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] num_patterns,
   input  logic [N-1:0]  poly,
   input  logic [N-1:0]  misr_seed,
   input  logic [N-1:0]  golden,
   input  logic [N-1:0]  resp,
   input  logic          resp_valid,
   output logic          lfsr_en,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [N-1:0]  signature
);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] issued_q, issued_d;
   logic [CW-1:0] recv_q, recv_d;
   logic          pass_q, pass_d;
   logic          load;
   logic          accept;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      issued_d = issued_q;
      recv_d   = recv_q;
      pass_d   = pass_q;
      load     = 1'b0;
      accept   = 1'b0;
      lfsr_en  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               load     = 1'b1;
               cnt_d    = num_patterns;
               issued_d = '0;
               recv_d   = '0;
               pass_d   = 1'b0;
               state_d  = (num_patterns == '0) ? ST_COMPARE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (issued_q < cnt_q) begin
               lfsr_en  = 1'b1;
               issued_d = issued_q + 1'b1;
            end
            // Exit is decided by responses alone; the last word was compacted
            // on the edge that made recv_q reach the count.
            if (recv_q == cnt_q) begin
               state_d = ST_COMPARE;
            end else if (resp_valid) begin
               accept = 1'b1;
               recv_d = recv_q + 1'b1;
            end
         end
         ST_COMPARE: begin
            pass_d  = (signature == golden);
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         issued_q <= '0;
         recv_q   <= '0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         issued_q <= issued_d;
         recv_q   <= recv_d;
         pass_q   <= pass_d;
      end
   end

   misr_reg #(.N(N)) u_misr (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (misr_seed),
      .en       (accept),
      .d        (resp),
      .poly     (poly),
      .q        (signature)
   );

   assign busy = (state_q == ST_RUN) || (state_q == ST_COMPARE);
   assign done = (state_q == ST_DONE);
   assign pass = pass_q;

endmodule

// File: tb/tb_bist_misr_ctrl.sv
// Scoreboard bench for bist_misr_ctrl: the driver queues expected results,
// a monitor checks them each time done rises.
module tb_bist_misr_ctrl;

   localparam int unsigned N  = 8;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CW-1:0] num_patterns;
   logic [N-1:0]  poly;
   logic [N-1:0]  misr_seed;
   logic [N-1:0]  golden;
   logic [N-1:0]  resp;
   logic          resp_valid;
   logic          lfsr_en;
   logic          busy;
   logic          done;
   logic          pass;
   logic [N-1:0]  signature;

   typedef struct {
      logic [N-1:0] sig;
      logic         pass;
      int           lfsr_cycles;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   lfsr_cnt = 0;
   logic done_prev = 1'b0;

   always #5 clk = ~clk;

   bist_misr_ctrl #(.N(N), .CW(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .num_patterns (num_patterns),
      .poly         (poly),
      .misr_seed    (misr_seed),
      .golden       (golden),
      .resp         (resp),
      .resp_valid   (resp_valid),
      .lfsr_en      (lfsr_en),
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .signature    (signature)
   );

   // Shift-and-mask form of the compaction step.
   function automatic logic [7:0] model(input logic [7:0] s, input logic [7:0] d,
                                        input logic [7:0] p);
      logic [7:0] fb;
      fb = s[0] ? {1'b1, p[6:0]} : 8'h00;
      return (s >> 1) ^ fb ^ d;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         lfsr_cnt  = 0;
         done_prev = 1'b0;
      end else begin
         if (lfsr_en === 1'b1) lfsr_cnt++;
         if (done === 1'b1 && done_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("signature", 32'(signature), 32'(e.sig));
               chk("pass", 32'(pass), 32'(e.pass));
               chk("lfsr_cycles", 32'(lfsr_cnt), 32'(e.lfsr_cycles));
            end
            lfsr_cnt = 0;
         end
         done_prev = done;
      end
   end

   task automatic do_start(input logic [CW-1:0] np, input logic [7:0] seed,
                           input logic [7:0] p, input logic [7:0] gold);
      @(negedge clk);
      num_patterns = np;
      misr_seed    = seed;
      poly         = p;
      golden       = gold;
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      resp       = d;
      resp_valid = 1'b1;
      @(negedge clk);
      resp_valid = 1'b0;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Called at the negedge right after the final accepted word.
   task automatic check_latency(input string name);
      chk({name, "_lat0"}, 32'(done), 32'd0);
      @(negedge clk);
      chk({name, "_lat1"}, 32'(done), 32'd0);
      @(negedge clk);
      chk({name, "_lat2"}, 32'(done), 32'd1);
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: got done=%0b expected 1", name, done);
      end
   endtask

   task automatic push(input logic [7:0] sig, input logic p, input int lc);
      exp_t e;
      e.sig = sig;
      e.pass = p;
      e.lfsr_cycles = lc;
      exp_q.push_back(e);
   endtask

   logic [7:0] words [10];
   logic [7:0] ref_sig;

   initial begin
      rst = 1'b1;
      start = 1'b0;
      num_patterns = '0;
      poly = '0;
      misr_seed = '0;
      golden = '0;
      resp = '0;
      resp_valid = 1'b0;
      #1;
      chk("rst_lfsr_en", 32'(lfsr_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_signature", 32'(signature), 32'd0);
      gap(2);
      rst = 1'b0;

      // Single word
      push(8'h5A, 1'b1, 1);
      do_start(1, 8'h00, 8'hB8, 8'h5A);
      send(8'h5A);
      check_latency("t1");

      // Two words, matching and mismatching golden
      push(8'hB8, 1'b1, 2);
      do_start(2, 8'h00, 8'hB8, 8'hB8);
      send(8'h01);
      send(8'h00);
      check_latency("t2a");
      push(8'hB8, 1'b0, 2);
      do_start(2, 8'h00, 8'hB8, 8'hB9);
      send(8'h01);
      send(8'h00);
      wait_done("t2b");

      // Zero patterns: RUN skipped
      push(8'h3C, 1'b1, 0);
      do_start(0, 8'h3C, 8'hB8, 8'h3C);
      chk("t3_busy", 32'(busy), 32'd1);
      wait_done("t3");

      // Gapped valids, stray start in RUN, extra valid after the last word
      push(8'h5C, 1'b1, 3);
      do_start(3, 8'h00, 8'hB8, 8'h5C);
      send(8'h01);
      start = 1'b1;
      misr_seed = 8'hFF;
      num_patterns = 16'd7;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      send(8'h00);
      send(8'h00);
      send(8'hFF);
      wait_done("t4");

      // Reset mid-run, then a clean rerun
      for (int i = 0; i < 10; i++) words[i] = 8'(i * 8'h13 + 8'h07);
      ref_sig = 8'h11;
      for (int i = 0; i < 10; i++) ref_sig = model(ref_sig, words[i], 8'hB8);
      do_start(10, 8'h11, 8'hB8, ref_sig);
      for (int i = 0; i < 5; i++) send(words[i]);
      rst = 1'b1;
      #1;
      chk("t5_rst_lfsr_en", 32'(lfsr_en), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_done", 32'(done), 32'd0);
      chk("t5_rst_signature", 32'(signature), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      push(ref_sig, 1'b1, 10);
      do_start(10, 8'h11, 8'hB8, ref_sig);
      for (int i = 0; i < 10; i++) send(words[i]);
      check_latency("t5");

      // Back-to-back start from DONE with a new seed
      push(8'hEA, 1'b1, 1);
      do_start(1, 8'hA5, 8'hB8, 8'hEA);
      chk("t6_done_drop", 32'(done), 32'd0);
      chk("t6_reload", 32'(signature), 32'hA5);
      send(8'h00);
      wait_done("t6");

      gap(3);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
